// File: rtl/mainmem_arb_pkg.sv
// Shared sizing constants and FSM encoding for the main-memory arbiter.
package mainmem_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned BEW     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/mainmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or above ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned cand;

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    idx_o = '0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_i) + (N - 1 - k)) % N;
      if (valid_i[IW'(cand)]) begin
        idx_o = IW'(cand);
      end
    end
  end

  assign any_o = |valid_i;

  always_comb begin
    grant_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      grant_o[i] = any_o && (idx_o == IW'(i));
    end
  end

endmodule

// File: rtl/mainmem_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters onto one main-memory port,
// one transaction outstanding at a time.
module mainmem_arbiter #(
  parameter int unsigned NUM_REQ = mainmem_arb_pkg::NUM_REQ,
  parameter int unsigned AW      = mainmem_arb_pkg::AW,
  parameter int unsigned DW      = mainmem_arb_pkg::DW
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ-1:0]                     req_write,
  input  logic [NUM_REQ*AW-1:0]                  req_addr,
  input  logic [NUM_REQ*DW-1:0]                  req_wdata,
  input  logic [NUM_REQ*mainmem_arb_pkg::BEW-1:0] req_be,
  output logic [NUM_REQ-1:0]                     resp_valid,
  output logic [DW-1:0]                          resp_rdata,
  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic                                   mem_req_write,
  output logic [AW-1:0]                          mem_req_addr,
  output logic [DW-1:0]                          mem_req_wdata,
  output logic [mainmem_arb_pkg::BEW-1:0]        mem_req_be,
  input  logic                                   mem_resp_valid,
  input  logic [DW-1:0]                          mem_resp_rdata,
  output logic                                   busy,
  output logic                                   err_spurious
);

  import mainmem_arb_pkg::*;

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic                 wr_q, wr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [BEW-1:0]       be_q, be_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [DW-1:0]        resp_rdata_q, resp_rdata_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  logic                 sel_write;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;
  logic [BEW-1:0]       sel_be;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Field mux for the winning requester.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
        sel_be    = req_be[i*BEW +: BEW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    err_d        = err_q;
    req_ready    = '0;

    if (mem_resp_valid && (state_q != ST_WAIT)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          owner_d   = pick_idx;
          wr_d      = sel_write;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          be_d      = sel_be;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          resp_rdata_d = mem_resp_rdata;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            resp_valid_d[i] = (owner_q == IW'(i));
          end
          rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      err_q        <= err_d;
    end
  end

  assign mem_req_valid = (state_q == ST_ISSUE);
  assign busy          = (state_q != ST_IDLE);
  assign mem_req_write = wr_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_be    = be_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign err_spurious  = err_q;

endmodule

// File: tb/tb_mainmem_arbiter.sv
// Directed bench for mainmem_arbiter: vector table of full transactions plus
// hand sequences for round-robin fairness, spurious responses and mid-flight reset.
module tb_mainmem_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_be;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_rdata;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_req_wdata;
  logic [3:0]   mem_req_be;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_rdata;
  logic         busy;
  logic         err_spurious;

  int checks = 0;
  int errors = 0;

  mainmem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_be     (mem_req_be),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .busy           (busy),
    .err_spurious   (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  write;
    logic [3:0]  exp_grant;
    logic [31:0] rdata;
    int          delay;
  } vec_t;

  vec_t vecs [8];

  function automatic int oh2idx(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] exp_addr(input int i);
    case (i)
      0: return 32'h0000_0100;
      1: return 32'h0000_0204;
      2: return 32'h0000_0308;
      default: return 32'h0000_040C;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input int i);
    case (i)
      0: return 32'h1111_0000;
      1: return 32'h2222_0000;
      2: return 32'h3333_0000;
      default: return 32'h0000_1234;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input int i);
    case (i)
      0: return 4'b1111;
      1: return 4'b0001;
      2: return 4'b1100;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; ends one step after the edge that raises resp_valid.
  task automatic run_txn(input vec_t v, input int n);
    int w;
    w = oh2idx(v.exp_grant);
    req_valid = v.valid;
    req_write = v.write;
    #1;
    chk($sformatf("v%0d req_ready", n), 64'(req_ready), 64'(v.exp_grant));
    tick();
    req_valid = '0;
    #1;
    chk($sformatf("v%0d issue busy", n), 64'(busy), 64'(1));
    chk($sformatf("v%0d mem_req_valid", n), 64'(mem_req_valid), 64'(1));
    chk($sformatf("v%0d mem_req_write", n), 64'(mem_req_write), 64'(|(v.write & v.exp_grant)));
    chk($sformatf("v%0d mem_req_addr", n), 64'(mem_req_addr), 64'(exp_addr(w)));
    chk($sformatf("v%0d mem_req_wdata", n), 64'(mem_req_wdata), 64'(exp_wdata(w)));
    chk($sformatf("v%0d mem_req_be", n), 64'(mem_req_be), 64'(exp_be(w)));
    for (int d = 0; d < v.delay; d++) begin
      req_valid = v.valid;
      tick();
      chk($sformatf("v%0d stall%0d req_ready", n, d), 64'(req_ready), 64'(0));
      chk($sformatf("v%0d stall%0d busy", n, d), 64'(busy), 64'(1));
      chk($sformatf("v%0d stall%0d mem_req_valid", n, d), 64'(mem_req_valid), 64'(1));
      chk($sformatf("v%0d stall%0d addr", n, d), 64'(mem_req_addr), 64'(exp_addr(w)));
      chk($sformatf("v%0d stall%0d be", n, d), 64'(mem_req_be), 64'(exp_be(w)));
      req_valid = '0;
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk($sformatf("v%0d wait mem_req_valid", n), 64'(mem_req_valid), 64'(0));
    chk($sformatf("v%0d wait resp_valid", n), 64'(resp_valid), 64'(0));
    mem_resp_valid = 1'b1;
    mem_resp_rdata = v.rdata;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    chk($sformatf("v%0d resp_valid", n), 64'(resp_valid), 64'(v.exp_grant));
    chk($sformatf("v%0d resp_rdata", n), 64'(resp_rdata), 64'(v.rdata));
    chk($sformatf("v%0d idle busy", n), 64'(busy), 64'(0));
  endtask

  initial begin
    logic got;
    logic [3:0] gexp;

    vecs[0] = '{4'b0001, 4'b0000, 4'b0001, 32'hDEAD_BEEF, 0};
    vecs[1] = '{4'b0001, 4'b0001, 4'b0001, 32'h0000_0001, 0};
    vecs[2] = '{4'b1111, 4'b0000, 4'b0010, 32'hC0FF_EE02, 0};
    vecs[3] = '{4'b1001, 4'b1000, 4'b1000, 32'h0000_0000, 0};
    vecs[4] = '{4'b0110, 4'b0000, 4'b0010, 32'h5A5A_0004, 0};
    vecs[5] = '{4'b0011, 4'b0000, 4'b0001, 32'h1234_5678, 5};
    vecs[6] = '{4'b1100, 4'b0100, 4'b0100, 32'h0BAD_0006, 0};
    vecs[7] = '{4'b0111, 4'b0000, 4'b0001, 32'h7777_7777, 0};

    rst_n          = 1'b0;
    req_valid      = '0;
    req_write      = '0;
    req_addr       = {32'h0000_040C, 32'h0000_0308, 32'h0000_0204, 32'h0000_0100};
    req_wdata      = {32'h0000_1234, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
    req_be         = {4'b0011, 4'b1100, 4'b0001, 4'b1111};
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;

    tick();
    tick();
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst mem_req_valid", 64'(mem_req_valid), 64'(0));
    chk("rst resp_valid", 64'(resp_valid), 64'(0));
    chk("rst resp_rdata", 64'(resp_rdata), 64'(0));
    chk("rst err_spurious", 64'(err_spurious), 64'(0));
    chk("rst mem_req_addr", 64'(mem_req_addr), 64'(0));
    chk("rst req_ready", 64'(req_ready), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("idle no req_ready", 64'(req_ready), 64'(0));

    for (int i = 0; i < 8; i++) run_txn(vecs[i], i);
    chk("table err_spurious", 64'(err_spurious), 64'(0));

    // All four requesters valid from reset: strict rotation 0,1,2,3,0.
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_write = '0;
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      gexp = 4'(1 << (t % 4));
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        #1;
        if (req_ready != 4'b0000) got = 1'b1;
        else tick();
      end
      chk($sformatf("rr grant%0d", t), 64'(req_ready), 64'(gexp));
      tick();
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = 32'hA5A5_0000 + 32'(t);
      tick();
      mem_resp_valid = 1'b0;
      chk($sformatf("rr resp%0d", t), 64'(resp_valid), 64'(gexp));
      chk($sformatf("rr rdata%0d", t), 64'(resp_rdata), 64'(32'hA5A5_0000 + 32'(t)));
    end
    req_valid = '0;
    tick();
    tick();

    // Response while idle is flagged and sticky until reset.
    chk("spur pre err", 64'(err_spurious), 64'(0));
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hFFFF_FFFF;
    tick();
    mem_resp_valid = 1'b0;
    chk("spur err set", 64'(err_spurious), 64'(1));
    chk("spur resp_valid", 64'(resp_valid), 64'(0));
    chk("spur busy", 64'(busy), 64'(0));
    tick();
    tick();
    tick();
    chk("spur err sticky", 64'(err_spurious), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("spur err cleared", 64'(err_spurious), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Reset asserted while requester 2 waits for its response.
    req_valid = 4'b0100;
    #1;
    chk("mid req_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    req_valid = '0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("mid wait busy", 64'(busy), 64'(1));
    chk("mid wait addr", 64'(mem_req_addr), 64'(32'h0000_0308));
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", 64'(busy), 64'(0));
    chk("mid rst mem_req_valid", 64'(mem_req_valid), 64'(0));
    chk("mid rst addr", 64'(mem_req_addr), 64'(0));
    chk("mid rst be", 64'(mem_req_be), 64'(0));
    chk("mid rst resp_rdata", 64'(resp_rdata), 64'(0));
    chk("mid rst resp_valid", 64'(resp_valid), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hCAFE_0002;
    tick();
    mem_resp_valid = 1'b0;
    chk("late resp_valid", 64'(resp_valid), 64'(0));
    chk("late err_spurious", 64'(err_spurious), 64'(1));
    tick();
    chk("late resp_valid next", 64'(resp_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mainmem_arbiter.md
MAINMEM_ARBITER -- requirements
Module: mainmem_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters (imem0, dmem0, imem1, dmem1 in index order 0..3).
REQ-002 Parameter: AW, 32, address width; DW, 32, data width.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  NUM_REQ  per-requester request valid.
REQ-006 req_ready  out  NUM_REQ  per-requester request accepted this cycle (one-hot or zero).
REQ-007 req_write  in  NUM_REQ  1 = write, 0 = read.
REQ-008 req_addr  in  NUM_REQ*AW  packed addresses, requester i at bits [i*AW +: AW].
REQ-009 req_wdata  in  NUM_REQ*DW  packed write data.
REQ-010 req_be  in  NUM_REQ*4  packed byte enables.
REQ-011 resp_valid  out  NUM_REQ  one-cycle response pulse to owner (read data or write ack).
REQ-012 resp_rdata  out  DW  response data, shared, valid when any resp_valid bit set.
REQ-013 mem_req_valid / mem_req_ready  out / in  1 / 1  main-memory request handshake.
REQ-014 mem_req_write, mem_req_addr, mem_req_wdata, mem_req_be  out  1, AW, DW, 4  latched request fields.
REQ-015 mem_resp_valid / mem_resp_rdata  in  1 / DW  main-memory response.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 err_spurious  out  1  sticky flag: memory response arrived outside WAIT.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT; one transaction outstanding at most.
REQ-019 IDLE: if any req_valid, winner = first valid index scanning from rr_ptr upward, modulo NUM_REQ; req_ready[winner]=1 combinationally that cycle; fields and owner latched; next state ISSUE.
REQ-020 IDLE with no req_valid: req_ready=0, stay IDLE.
REQ-021 ISSUE: mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 go WAIT, else stay.
REQ-022 WAIT: on mem_resp_valid=1, register mem_resp_rdata into resp_rdata, set resp_valid[owner]=1 for exactly the next cycle, rr_ptr <= (owner+1) mod NUM_REQ, go IDLE.
REQ-023 Response pulse cycle and a new IDLE acceptance SHALL be allowed to coincide.
REQ-024 req_ready SHALL be 0 in ISSUE and WAIT; requesters hold req_valid until accepted.
REQ-025 mem_resp_valid in IDLE or ISSUE: ignored for routing, err_spurious <= 1 (sticky until reset).
REQ-026 Minimum accept-to-resp_valid latency: 3 cycles (accept, ISSUE with ready, WAIT with resp, pulse).
REQ-027 rr_ptr advances only on completion; wraps 3 -> 0.

Reset
REQ-028 RST_N low: state IDLE, rr_ptr 0, owner 0, latched fields 0, resp_valid 0, resp_rdata 0, err_spurious 0, busy 0, mem_req_valid 0, immediately (asynchronous).
REQ-029 Reset mid-transaction abandons it; no response pulse is issued after release.

Structure
REQ-030 Shared package mainmem_arb_pkg holds NUM_REQ, AW, DW, BE width and the state enum.
REQ-031 Sub-module rr_pick: combinational round-robin picker (valid vector, pointer in; one-hot grant, index, any out).
REQ-032 All registers in a single clocked process with asynchronous active-low reset.

Verification
REQ-033 Single read: req_valid=0001, addr 0x100, mem_req_ready=1, mem_resp rdata 0xDEADBEEF one cycle after ISSUE -> resp_valid=0001 with 0xDEADBEEF, 3 cycles after accept.
REQ-034 All four valid continuously from reset -> grants in order 0,1,2,3,0; no requester granted twice before others.
REQ-035 mem_req_ready held 0 for 5 cycles in ISSUE -> mem_req fields stable, req_ready=0000, busy=1 throughout.
REQ-036 mem_resp_valid pulsed while IDLE -> err_spurious=1, no resp_valid, remains 1 until RST_N low.
REQ-037 RST_N asserted in WAIT for requester 2 -> outputs zero immediately; after release, late mem_resp sets err_spurious, no resp_valid[2].
REQ-038 Write from requester 3 (be=0011, wdata 0x1234) -> mem_req_write=1, be=0011, resp_valid=1000 ack on completion.
